// File: rtl/normb.sv
// normb: iterative leading-zero normalizer (binary search, one stage per cycle).
// Ports: clk, nreset (async low); in_valid/in_ready/a in; out_valid/out_ready,
//        out (a << count), count (leading zeros, saturates at DW-1), zero (a==0).
module normb #(
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out,
    output logic [$clog2(DW)-1:0] count,
    output logic                  zero
);
    localparam int LOG2 = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_data;
    logic [LOG2-1:0] r_count;
    logic [LOG2-1:0] r_k;
    logic            r_zero;

    logic [LOG2:0]   w_sh;
    logic [DW-1:0]   w_mask;
    logic            w_top_zero;
    logic            w_start;

    // Stage k inspects the top 2^k bits of the working word.
    assign w_sh       = {{LOG2{1'b0}}, 1'b1} << r_k;
    assign w_mask     = ~({DW{1'b1}} >> w_sh);
    assign w_top_zero = ((r_data & w_mask) == '0);
    assign w_start    = (r_state == S_IDLE) && in_valid;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_RUN;
            S_RUN:  if (r_k == '0) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_data  <= '0;
            r_count <= '0;
            r_k     <= '0;
            r_zero  <= 1'b0;
        end else if (w_start) begin
            r_data  <= a;
            r_count <= '0;
            r_k     <= LOG2[LOG2-1:0] - 1'b1;
            r_zero  <= (a == '0);
        end else if (r_state == S_RUN) begin
            // An all-zero word shifts at every stage, giving count = DW-1.
            if (w_top_zero) begin
                r_data       <= r_data << w_sh;
                r_count[r_k] <= 1'b1;
            end
            r_k <= r_k - 1'b1;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_data;
    assign count     = r_count;
    assign zero      = r_zero;

endmodule

// File: tb/tb_normb.sv
// tb_normb: scoreboard bench for normb (DW=32).
// Directed cases, backpressure, mid-run reset and a random regression.
module tb_normb;

    typedef struct {
        logic [31:0] a;
        logic [31:0] out;
        logic [4:0]  cnt;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        nreset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [4:0]  count;
    logic        zero;

    int n_tests;
    int n_fail;
    bit rnd_ready;
    exp_t sb[$];

    normb #(.DW(32)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .count     (count),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   lz;
        lz = 0;
        for (int i = 31; i >= 0; i--) begin
            if (w[i]) break;
            lz++;
        end
        if (lz > 31) lz = 31;
        e.a    = w;
        e.cnt  = 5'(lz);
        e.out  = w << lz;
        e.zero = (w == 32'h0);
        return e;
    endfunction

    // Push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        if (nreset && in_valid && in_ready) sb.push_back(model(a));
        if (nreset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_spurious", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", out, e.out);
                chk("count", {27'd0, count}, {27'd0, e.cnt});
                chk("zero", {31'd0, zero}, {31'd0, e.zero});
                chk("recover", out >> count, e.a);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] w);
        int n;
        in_valid = 1'b1;
        a        = w;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int n;
        logic [31:0] w;
        n_tests   = 0;
        n_fail    = 0;
        rnd_ready = 1'b0;
        nreset    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", out, 32'h0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Latency: out_valid five edges after the input handshake.
        send(32'h0000_0001);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 32'd5);
        chk("d1_out", out, 32'h8000_0000);
        chk("d1_count", {27'd0, count}, 32'd31);
        @(posedge clk);
        #1;
        chk("d1_in_ready", {31'd0, in_ready}, 32'd1);

        send(32'h0001_2345);
        wait_idle();
        chk("d2_count", {27'd0, count}, 32'd15);
        send(32'h8000_0000);
        wait_idle();
        send(32'h0000_0000);
        wait_idle();
        chk("d4_zero", {31'd0, zero}, 32'd1);

        // Backpressure hold.
        out_ready = 1'b0;
        send(32'h0000_F000);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out", out, 32'hF000_0000);
            chk("bp_count", {27'd0, count}, 32'd16);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Reset during stage k=2; the in-flight result must vanish.
        send(32'h0000_FFFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out", out, 32'h0);
        chk("mr_count", {27'd0, count}, 32'd0);
        chk("mr_zero", {31'd0, zero}, 32'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("mr_no_result", {31'd0, out_valid}, 32'd0);
        end
        send(32'h0000_0100);
        wait_idle();
        chk("mr_count2", {27'd0, count}, 32'd23);
        chk("mr_out2", out, 32'h8000_0000);

        // Random regression with handshake gaps.
        rnd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w = 32'h1 << i;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(w);
        end
        for (int i = 0; i < 2000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) == 0) w = 32'h0;
            else w = w >> $urandom_range(0, 31);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(w);
        end
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        rnd_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
